// File: rtl/idu_mt.sv
// rtl/idu_mt.sv - multi-thread RV32 instruction decode with 2-entry uop buffer
// Decode is combinational at the input; the buffer head drives every output.
module idu_mt #(
  parameter int XLEN    = 32,
  parameter int THREADS = 4,
  parameter int M_EXT   = 0,
  localparam int TID_W  = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TID_W-1:0] in_tid,
  input  logic             flush,
  input  logic [TID_W-1:0] flush_tid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_class,
  output logic [2:0]       out_rs_en,
  output logic [14:0]      out_regs,
  output logic [2:0]       out_fn3,
  output logic             out_sub,
  output logic             out_sra,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [TID_W-1:0] out_tid
);

  typedef enum logic [3:0] {
    C_ALU = 4'd0, C_ALU_IMM = 4'd1, C_LUI = 4'd2, C_AUIPC = 4'd3, C_JAL = 4'd4,
    C_JALR = 4'd5, C_BRANCH = 4'd6, C_LOAD = 4'd7, C_STORE = 4'd8,
    C_MULDIV = 4'd9, C_ILLEGAL = 4'd15
  } cls_e;

  typedef struct packed {
    logic [3:0]       cls;
    logic [2:0]       rs_en;
    logic [14:0]      regs;
    logic [2:0]       fn3;
    logic             sub;
    logic             sra;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [TID_W-1:0] tid;
  } uop_t;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm32;
  cls_e        cls;
  logic [2:0]  en;
  logic        sub, sra;
  uop_t        dec;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];
  assign rd  = in_inst[11:7];

  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_sh = {27'b0, in_inst[24:20]};

  always_comb begin
    cls   = C_ILLEGAL;
    en    = 3'b000;
    sub   = 1'b0;
    sra   = 1'b0;
    imm32 = 32'b0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          cls = C_ALU;
          en  = 3'b111;
          sub = (f3 == 3'b000 && in_inst[30]) || f3 == 3'b010 || f3 == 3'b011;
          sra = (f3 == 3'b101) && in_inst[30];
        end else if (f7 == 7'b0000001 && M_EXT != 0) begin
          cls = C_MULDIV;
          en  = 3'b111;
        end
      end
      7'b0010011: begin
        if (!((f3 == 3'b001 && f7 != 7'b0000000) ||
              (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000))) begin
          cls   = C_ALU_IMM;
          en    = 3'b101;
          sub   = (f3 == 3'b010) || (f3 == 3'b011);
          sra   = (f3 == 3'b101) && in_inst[30];
          imm32 = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
        end
      end
      7'b0110111: begin cls = C_LUI;   en = 3'b100; imm32 = imm_u; end
      7'b0010111: begin cls = C_AUIPC; en = 3'b100; imm32 = imm_u; end
      7'b1101111: begin cls = C_JAL;   en = 3'b100; imm32 = imm_j; end
      7'b1100111: begin
        if (f3 == 3'b000) begin cls = C_JALR; en = 3'b101; imm32 = imm_i; end
      end
      7'b1100011: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          cls = C_BRANCH; en = 3'b011; sub = 1'b1; imm32 = imm_b;
        end
      end
      7'b0000011: begin
        if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
          cls = C_LOAD; en = 3'b101; imm32 = imm_i;
        end
      end
      7'b0100011: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
          cls = C_STORE; en = 3'b011; imm32 = imm_s;
        end
      end
      default: ;
    endcase
  end

  // imm32 bit 31 is the sign for every format, so replicate it out to XLEN
  always_comb begin
    dec       = '0;
    dec.cls   = cls;
    dec.rs_en = {en[2] && (rd != 5'd0), en[1:0]};
    dec.regs  = {rd, in_inst[24:20], in_inst[19:15]};
    dec.fn3   = f3;
    dec.sub   = sub;
    dec.sra   = sra;
    dec.imm   = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    dec.pc    = in_pc;
    dec.tid   = in_tid;
  end

  uop_t       ent0, ent1, a_ent, slot0, slot1;
  logic [1:0] count, count_nxt;
  logic       push, pop, a_v, ka, kb, kp;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // After the pop, survivors of the flush are compacted toward the head
  always_comb begin
    a_ent     = pop ? ent1 : ent0;
    a_v       = pop ? (count == 2'd2) : (count != 2'd0);
    ka        = a_v && !(flush && a_ent.tid == flush_tid);
    kb        = !pop && (count == 2'd2) && !(flush && ent1.tid == flush_tid);
    kp        = push && !(flush && in_tid == flush_tid);
    slot0     = ka ? a_ent : (kb ? ent1 : dec);
    slot1     = (ka && kb) ? ent1 : dec;
    count_nxt = 2'(ka) + 2'(kb) + 2'(kp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      count <= count_nxt;
      if (count_nxt != 2'd0) ent0 <= slot0;
      if (count_nxt == 2'd2) ent1 <= slot1;
    end
  end

  assign out_class = ent0.cls;
  assign out_rs_en = ent0.rs_en;
  assign out_regs  = ent0.regs;
  assign out_fn3   = ent0.fn3;
  assign out_sub   = ent0.sub;
  assign out_sra   = ent0.sra;
  assign out_imm   = ent0.imm;
  assign out_pc    = ent0.pc;
  assign out_tid   = ent0.tid;

endmodule

// File: tb/tb_idu_mt.sv
// tb/tb_idu_mt.sv - bench for idu_mt: decode vector table, directed buffer/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_idu_mt;

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_imm, out_pc;
  logic [1:0]  in_tid, flush_tid, out_tid;
  logic [3:0]  out_class;
  logic [2:0]  out_rs_en, out_fn3;
  logic [14:0] out_regs;
  logic        out_sub, out_sra;

  logic        m_in_ready, m_out_valid, m_out_sub, m_out_sra;
  logic [31:0] m_out_imm, m_out_pc;
  logic [1:0]  m_out_tid;
  logic [3:0]  m_out_class;
  logic [2:0]  m_out_rs_en, m_out_fn3;
  logic [14:0] m_out_regs;

  idu_mt #(.XLEN(32), .THREADS(4), .M_EXT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_tid(in_tid), .flush(flush),
    .flush_tid(flush_tid), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_rs_en(out_rs_en), .out_regs(out_regs),
    .out_fn3(out_fn3), .out_sub(out_sub), .out_sra(out_sra),
    .out_imm(out_imm), .out_pc(out_pc), .out_tid(out_tid)
  );

  idu_mt #(.XLEN(32), .THREADS(4), .M_EXT(1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_tid(in_tid), .flush(flush),
    .flush_tid(flush_tid), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_class(m_out_class), .out_rs_en(m_out_rs_en), .out_regs(m_out_regs),
    .out_fn3(m_out_fn3), .out_sub(m_out_sub), .out_sra(m_out_sra),
    .out_imm(m_out_imm), .out_pc(m_out_pc), .out_tid(m_out_tid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference decode: class, enables, raw register fields, funct3, sub, sra, immediate
  function automatic logic [60:0] ref_fields(input logic [31:0] i, input bit mext);
    logic [6:0]  op, f7;
    logic [2:0]  f3, en;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        sub, sra;
    op = i[6:0]; f7 = i[31:25]; f3 = i[14:12];
    cls = 4'd15; en = 3'b000; imm = 32'd0; sub = 1'b0; sra = 1'b0;
    case (op)
      7'h33: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          cls = 4'd0; en = 3'b111;
          sub = (f7 == 7'h20 && f3 == 3'd0) || f3 == 3'd2 || f3 == 3'd3;
          sra = (f7 == 7'h20 && f3 == 3'd5);
        end else if (f7 == 7'h01 && mext) begin
          cls = 4'd9; en = 3'b111;
        end
      end
      7'h13: begin
        if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
          cls = 4'd1; en = 3'b101;
          imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, i[24:20]} : {{20{i[31]}}, i[31:20]};
          sub = (f3 == 3'd2 || f3 == 3'd3);
          sra = (f3 == 3'd5 && i[30]);
        end
      end
      7'h37: begin cls = 4'd2; en = 3'b100; imm = {i[31:12], 12'd0}; end
      7'h17: begin cls = 4'd3; en = 3'b100; imm = {i[31:12], 12'd0}; end
      7'h6f: begin cls = 4'd4; en = 3'b100; imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      7'h67: if (f3 == 3'd0) begin cls = 4'd5; en = 3'b101; imm = {{20{i[31]}}, i[31:20]}; end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        cls = 4'd6; en = 3'b011; sub = 1'b1;
        imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        cls = 4'd7; en = 3'b101; imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: if (f3 <= 3'd2) begin
        cls = 4'd8; en = 3'b011; imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      default: ;
    endcase
    if (i[11:7] == 5'd0) en[2] = 1'b0;
    return {cls, en, i[11:7], i[24:20], i[19:15], f3, sub, sra, imm};
  endfunction

  typedef struct { logic [31:0] inst; logic [31:0] pc; logic [1:0] tid; } ent_t;
  ent_t mq[$];

  task automatic check_model();
    logic [60:0] f0, f1;
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("m_in_ready", m_in_ready, mq.size() < 2);
    chk("m_out_valid", m_out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      f0 = ref_fields(mq[0].inst, 1'b0);
      f1 = ref_fields(mq[0].inst, 1'b1);
      chk("head_uop", {out_class, out_rs_en, out_regs, out_fn3, out_sub, out_sra, out_imm, out_pc, out_tid},
          {f0, mq[0].pc, mq[0].tid});
      chk("m_head_uop", {m_out_class, m_out_rs_en, m_out_regs, m_out_fn3, m_out_sub, m_out_sra, m_out_imm,
                         m_out_pc, m_out_tid}, {f1, mq[0].pc, mq[0].tid});
    end
  endtask

  // Called at a negedge: apply inputs, advance the model one edge, check after the edge
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic [1:0] tid,
                       input logic fl, input logic [1:0] ftid, input logic ordy);
    ent_t keep[$];
    bit   acc;
    in_valid = v; in_inst = inst; in_pc = pc; in_tid = tid;
    flush = fl; flush_tid = ftid; out_ready = ordy;
    acc = v && (mq.size() < 2);
    if (mq.size() > 0 && ordy) void'(mq.pop_front());
    if (fl) begin
      foreach (mq[k]) if (mq[k].tid != ftid) keep.push_back(mq[k]);
      mq = keep;
    end
    if (acc && !(fl && tid == ftid)) mq.push_back('{inst, pc, tid});
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int s;
    w = $urandom;
    s = $urandom_range(0, 11);
    case (s)
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h37;  3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h6f;  5: w[6:0] = 7'h67;  6: w[6:0] = 7'h63;  7: w[6:0] = 7'h03;
      8: w[6:0] = 7'h23;  9: w[6:0] = 7'h73;  default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;  2: w[31:25] = 7'h01;  default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  typedef struct {
    logic [31:0] inst; logic [3:0] cls; logic [3:0] cls_m; logic [2:0] en;
    logic [31:0] imm; logic sub; logic sra; logic [4:0] rd; logic [4:0] rs1;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{32'hFFF08293, 4'd1,  4'd1,  3'b101, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd5,  5'd1};
    tbl[1]  = '{32'hFE000EE3, 4'd6,  4'd6,  3'b011, 32'hFFFFFFFC, 1'b1, 1'b0, 5'd29, 5'd0};
    tbl[2]  = '{32'h02208033, 4'd15, 4'd9,  3'b000, 32'h00000000, 1'b0, 1'b0, 5'd0,  5'd1};
    tbl[3]  = '{32'h00000000, 4'd15, 4'd15, 3'b000, 32'h00000000, 1'b0, 1'b0, 5'd0,  5'd0};
    tbl[4]  = '{32'h402081B3, 4'd0,  4'd0,  3'b111, 32'h00000000, 1'b1, 1'b0, 5'd3,  5'd1};
    tbl[5]  = '{32'h4033D313, 4'd1,  4'd1,  3'b101, 32'h00000003, 1'b0, 1'b1, 5'd6,  5'd7};
    tbl[6]  = '{32'h12345537, 4'd2,  4'd2,  3'b100, 32'h12345000, 1'b0, 1'b0, 5'd10, 5'd8};
    tbl[7]  = '{32'h008000EF, 4'd4,  4'd4,  3'b100, 32'h00000008, 1'b0, 1'b0, 5'd1,  5'd0};
    tbl[8]  = '{32'hFE21AE23, 4'd8,  4'd8,  3'b011, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd28, 5'd3};
    tbl[9]  = '{32'h0102A203, 4'd7,  4'd7,  3'b101, 32'h00000010, 1'b0, 1'b0, 5'd4,  5'd5};
    tbl[10] = '{32'h00000013, 4'd1,  4'd1,  3'b001, 32'h00000000, 1'b0, 1'b0, 5'd0,  5'd0};
    tbl[11] = '{32'h40001013, 4'd15, 4'd15, 3'b000, 32'h00000000, 1'b0, 1'b0, 5'd0,  5'd0};
    tbl[12] = '{32'h000090E7, 4'd15, 4'd15, 3'b000, 32'h00000000, 1'b0, 1'b0, 5'd1,  5'd1};
    tbl[13] = '{32'h00001097, 4'd3,  4'd3,  3'b100, 32'h00001000, 1'b0, 1'b0, 5'd1,  5'd0};
    tbl[14] = '{32'h003120B3, 4'd0,  4'd0,  3'b111, 32'h00000000, 1'b1, 1'b0, 5'd1,  5'd2};

    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_tid = '0;
    flush = 1'b0; flush_tid = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_data", {out_class, out_rs_en, out_regs, out_imm, out_pc, out_tid}, '0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[k]) begin
      drive(1'b1, tbl[k].inst, 32'h1000 + 32'(k) * 4, 2'(k), 1'b0, 2'd0, 1'b1);
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_class", out_class, tbl[k].cls);
      chk("tbl_class_m", m_out_class, tbl[k].cls_m);
      chk("tbl_rs_en", out_rs_en, tbl[k].en);
      chk("tbl_imm", out_imm, tbl[k].imm);
      chk("tbl_sub_sra", {out_sub, out_sra}, {tbl[k].sub, tbl[k].sra});
      chk("tbl_rd_rs1", {out_regs[14:10], out_regs[4:0]}, {tbl[k].rd, tbl[k].rs1});
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("drain_empty", out_valid, 1'b0);

    // Backpressure: A, B fill the buffer, C waits for space
    drive(1'b1, 32'h00108093, 32'hA0, 2'd0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 32'h00210113, 32'hB0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("bp_full", in_ready, 1'b0);
    chk("bp_head_a", out_pc, 32'hA0);
    drive(1'b1, 32'h00318193, 32'hC0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("bp_hold_a", out_pc, 32'hA0);
    drive(1'b1, 32'h00318193, 32'hC0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("bp_head_b", out_pc, 32'hB0);
    drive(1'b1, 32'h00318193, 32'hC0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("bp_head_c", out_pc, 32'hC0);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("bp_empty", out_valid, 1'b0);

    // Flush of tid2 removes Y and discards pushes from tid2; X survives alone
    drive(1'b1, 32'h00500293, 32'hD0, 2'd1, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 32'h00600313, 32'hE0, 2'd2, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 32'h00700393, 32'hF0, 2'd2, 1'b1, 2'd2, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    drive(1'b1, 32'h00700393, 32'hF4, 2'd2, 1'b1, 2'd2, 1'b0);
    chk("fl_push_dropped", in_ready, 1'b1);
    chk("fl_head_x", out_pc, 32'hD0);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("fl_only_x", out_valid, 1'b0);

    // Reset with two uops buffered
    drive(1'b1, 32'h00108093, 32'h200, 2'd3, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 32'h00210113, 32'h204, 2'd3, 1'b0, 2'd0, 1'b0);
    chk("pre_rst_full", in_ready, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("rst_async_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
    chk("rst_rel_ready", in_ready, 1'b1);
    chk("rst_rel_data", {out_class, out_imm, out_pc}, '0);
    check_model();

    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 6) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
